// File: rtl/sum4_stream.sv
// Purpose    : streaming group adder; sums each group of COUNT serial operands into a WIDTH-bit wrapped sum plus carry.
// Latency    : result is visible one cycle after the completing beat; one operand per cycle sustained.
// Backpressure: only the completing beat stalls, when the one-entry result register is held by out_ready=0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand stream handshake; in_data is the unsigned operand
//   in_clear            synchronous discard of the partial group (wins over a coincident beat)
//   out_valid/out_ready result stream handshake
//   out_sum, out_carry  group sum modulo 2^WIDTH, and 1 when the true sum overflowed WIDTH bits
module sum4_stream #(
    parameter int WIDTH = 8,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
);

    // Accumulator is wide enough for COUNT full-scale operands, so it never wraps internally.
    localparam int ACCW = WIDTH + $clog2(COUNT);
    localparam int IDXW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(COUNT - 1);

    logic [ACCW-1:0]  acc_q, acc_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_carry_q, out_carry_d;

    logic             beat;
    logic             complete;
    logic             xfer;
    logic [ACCW-1:0]  total;

    // Depends only on state and out_ready; never on in_valid.
    assign in_ready = (idx_q != LAST) || !out_valid_q || out_ready;
    assign beat     = in_valid && in_ready && !in_clear;
    assign complete = beat && (idx_q == LAST);
    assign xfer     = out_valid_q && out_ready;
    assign total    = acc_q + {{(ACCW-WIDTH){1'b0}}, in_data};

    always_comb begin
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;

        if (in_clear) begin
            acc_d = '0;
            idx_d = '0;
        end else if (beat) begin
            if (idx_q == LAST) begin
                acc_d = '0;
                idx_d = '0;
            end else begin
                acc_d = total;
                idx_d = idx_q + IDXW'(1);
            end
        end

        // A completing beat reloads the register even while the old result
        // is leaving, so back-to-back groups produce no bubble.
        if (complete) begin
            out_valid_d = 1'b1;
            out_sum_d   = total[WIDTH-1:0];
            out_carry_d = |total[ACCW-1:WIDTH];
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_carry = out_carry_q;

endmodule

// File: tb/tb_sum4_stream.sv
// Purpose    : self-checking bench for sum4_stream with a reference model and result scoreboard.
// Latency    : inputs change on negedge; outputs are sampled 1 time unit before each posedge.
// Backpressure: out_ready is steered per scenario; the driver holds an operand until in_ready is seen.
module tb_sum4_stream;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_clear;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    int nres   = 0;

    // Reference model state and expected {carry, sum} queue.
    int          m_acc = 0;
    int          m_idx = 0;
    logic [W:0]  sbq[$];

    always #5 clk = ~clk;

    sum4_stream #(.WIDTH(W), .COUNT(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_clear  (in_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [W-1:0] d);
        int t;
        t = m_acc + int'(d);
        if (m_idx == N - 1) begin
            sbq.push_back({(t >= (1 << W)) ? 1'b1 : 1'b0, W'(t)});
            m_acc = 0;
            m_idx = 0;
        end else begin
            m_acc = t;
            m_idx = m_idx + 1;
        end
    endtask

    task automatic model_reset();
        m_acc = 0;
        m_idx = 0;
    endtask

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send(input logic [W-1:0] d);
        int   n;
        logic ok;
        logic done;
        in_valid = 1'b1;
        in_data  = d;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            #4;
            ok = in_ready;
            @(posedge clk);
            if (ok) begin
                model_accept(d);
                done = 1'b1;
            end else begin
                stalls++;
                n++;
                if (n > 50) begin
                    chk("send_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    // Output monitor: a transfer is decided by the values just before the edge.
    always @(negedge clk) begin
        #4;
        if (rst_n && out_valid && out_ready) begin
            nres++;
            if (sbq.size() == 0) begin
                chk("unexpected_result", {23'd0, out_carry, out_sum}, 32'hFFFF_FFFF);
            end else begin
                chk("result", {23'd0, out_carry, out_sum}, {23'd0, sbq.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_clear  = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_out_carry", 32'(out_carry), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Basic group and one-cycle latency.
        send(8'd4); send(8'd5); send(8'd11); send(8'd9);
        in_valid = 1'b0;
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_sum",   32'(out_sum),   32'd29);
        chk("lat_carry", 32'(out_carry), 32'd0);
        @(negedge clk);
        chk("drop_valid", 32'(out_valid), 32'd0);

        // Two groups streamed with no gaps; no stalls expected.
        stalls = 0;
        send(8'd15);  send(8'd3);   send(8'd200); send(8'd7);
        send(8'd200); send(8'd100); send(8'd50);  send(8'd10);
        chk("stream_stalls", 32'(stalls), 32'd0);
        idle(2);

        // Extremes.
        send(8'd255); send(8'd255); send(8'd255); send(8'd255);
        in_valid = 1'b0;
        chk("max_sum",   32'(out_sum),   32'd252);
        chk("max_carry", 32'(out_carry), 32'd1);
        send(8'd0); send(8'd0); send(8'd0); send(8'd0);
        in_valid = 1'b0;
        chk("zero_sum",   32'(out_sum),   32'd0);
        chk("zero_carry", 32'(out_carry), 32'd0);
        idle(2);

        // Backpressure: held result stalls only the completing beat.
        out_ready = 1'b0;
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        in_valid = 1'b0;
        idle(2);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_sum",   32'(out_sum),   32'd10);
        send(8'd5); send(8'd6); send(8'd7);
        in_valid = 1'b1;
        in_data  = 8'd8;
        #4;
        chk("bp_stall_ready0", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #4;
        chk("bp_stall_ready1", 32'(in_ready), 32'd0);
        chk("bp_stable_sum",   32'(out_sum),  32'd10);
        @(negedge clk);
        out_ready = 1'b1;
        #4;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        model_accept(8'd8);
        #1;
        chk("bp_no_bubble", 32'(out_valid), 32'd1);
        chk("bp_new_sum",   32'(out_sum),   32'd26);
        @(negedge clk);
        idle(2);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // in_clear discards the partial group and a coincident operand.
        send(8'd10); send(8'd20);
        in_clear = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd99;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        in_clear = 1'b0;
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        in_valid = 1'b0;
        chk("clr_sum",   32'(out_sum),   32'd10);
        chk("clr_carry", 32'(out_carry), 32'd0);
        idle(2);

        // Asynchronous reset mid-group.
        send(8'd1); send(8'd2);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst1_valid", 32'(out_valid), 32'd0);
        chk("arst1_sum",   32'(out_sum),   32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset with a result pending.
        out_ready = 1'b0;
        send(8'd7); send(8'd7); send(8'd7); send(8'd7);
        in_valid = 1'b0;
        chk("pend_sum", 32'(out_sum), 32'd28);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst2_valid", 32'(out_valid), 32'd0);
        chk("arst2_sum",   32'(out_sum),   32'd0);
        chk("arst2_carry", 32'(out_carry), 32'd0);
        sbq.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        send(8'd4); send(8'd5); send(8'd11); send(8'd9);
        in_valid = 1'b0;
        chk("post_rst_sum", 32'(out_sum), 32'd29);
        idle(3);

        chk("sb_empty",  32'(sbq.size()), 32'd0);
        chk("n_results", 32'(nres),       32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
